// File: rtl/dcache_miss_tracker.sv
// dcache_miss_tracker
//
// Tracks outstanding L1 data cache line misses, one tracker entry per hardware
// thread. It issues line fill requests to the L2 and, when a fill returns,
// produces the bitmap of threads to wake. Misses to a line that is already
// pending are merged into that entry, so one fill wakes every waiting thread.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   dd_miss_en            a dcache miss occurred this cycle
//   dd_miss_addr          line address of the miss
//   dd_miss_thread_idx    thread that missed
//   l2r_request_valid     fill request pending (combinational from entry state)
//   l2r_request_addr      line address of the granted entry
//   l2r_request_idx       tag of the granted entry, returned with the response
//   l2r_request_ack       L2 accepted the presented request this cycle
//   l2_response_valid     fill complete
//   l2_response_idx       tag of the completed fill
//   dmt_wake_bitmap       threads to wake, a one-cycle registered pulse
//   dmt_pending_count     number of non-IDLE entries (registered)
//
// Request handshake: a request transfers on a cycle where l2r_request_valid
// and l2r_request_ack are both high. Once presented, addr/idx stay fixed until
// that transfer happens; the L2 may hold ack low for any number of cycles.

module dcache_miss_tracker #(
    parameter int THREADS         = 4,
    parameter int LINE_ADDR_WIDTH = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dd_miss_en,
    input  logic [LINE_ADDR_WIDTH-1:0] dd_miss_addr,
    input  logic [$clog2(THREADS)-1:0] dd_miss_thread_idx,
    output logic                       l2r_request_valid,
    output logic [LINE_ADDR_WIDTH-1:0] l2r_request_addr,
    output logic [$clog2(THREADS)-1:0] l2r_request_idx,
    input  logic                       l2r_request_ack,
    input  logic                       l2_response_valid,
    input  logic [$clog2(THREADS)-1:0] l2_response_idx,
    output logic [THREADS-1:0]         dmt_wake_bitmap,
    output logic [$clog2(THREADS):0]   dmt_pending_count
);

    localparam int IDX_W = $clog2(THREADS);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE          = 2'd0;
    localparam logic [1:0] ST_WAIT_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_RESPONSE = 2'd2;

    // Per-entry storage
    logic [1:0]                 state_q   [THREADS];
    logic [LINE_ADDR_WIDTH-1:0] addr_q    [THREADS];
    logic [THREADS-1:0]         waiters_q [THREADS];
    logic [1:0]                 state_d   [THREADS];
    logic [LINE_ADDR_WIDTH-1:0] addr_d    [THREADS];
    logic [THREADS-1:0]         waiters_d [THREADS];

    // Arbiter state
    logic [IDX_W-1:0] lru_ptr_q;
    logic             hold_q;
    logic [IDX_W-1:0] hold_idx_q;

    logic [THREADS-1:0] wake_q;
    logic [CNT_W-1:0]   pending_q;

    // Combinational
    logic [THREADS-1:0] miss_onehot;
    logic [THREADS-1:0] issue_vec;
    logic [THREADS-1:0] match_vec;
    logic [THREADS-1:0] all_waiters;
    logic               merge_hit;
    logic               alloc;
    logic [IDX_W-1:0]   merge_idx;
    logic [IDX_W-1:0]   rr_grant;
    logic [IDX_W-1:0]   grant;
    logic               req_valid;
    logic               ack_fire;
    logic               resp_fire;
    logic [THREADS-1:0] wake_d;
    logic [CNT_W-1:0]   pending_d;
    logic [IDX_W-1:0]   lru_ptr_d;

    // Merge check and entry summaries
    always_comb begin
        miss_onehot = '0;
        miss_onehot[dd_miss_thread_idx] = 1'b1;
        issue_vec   = '0;
        match_vec   = '0;
        all_waiters = '0;
        for (int i = 0; i < THREADS; i++) begin
            issue_vec[i] = (state_q[i] == ST_WAIT_ISSUE);
            match_vec[i] = (state_q[i] != ST_IDLE) && (addr_q[i] == dd_miss_addr);
            all_waiters  = all_waiters | waiters_q[i];
        end
        // At most one entry can hold a given line; lowest index wins regardless.
        merge_idx = '0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (match_vec[i]) merge_idx = IDX_W'(i);
        end
        merge_hit = dd_miss_en && (|match_vec);
        alloc     = dd_miss_en && !(|match_vec);
    end

    // Round-robin search starting at the LRU pointer
    always_comb begin
        int c;
        logic found;
        c        = 0;
        found    = 1'b0;
        rr_grant = '0;
        for (int k = 0; k < THREADS; k++) begin
            c = (int'(lru_ptr_q) + k) % THREADS;
            if (!found && issue_vec[c]) begin
                found    = 1'b1;
                rr_grant = IDX_W'(c);
            end
        end
    end

    // A request left waiting for ack keeps its grant, even if a newly
    // allocated entry would now win the round-robin search.
    assign grant     = hold_q ? hold_idx_q : rr_grant;
    assign req_valid = |issue_vec;
    assign ack_fire  = req_valid && l2r_request_ack;
    assign resp_fire = l2_response_valid && (state_q[l2_response_idx] == ST_WAIT_RESPONSE);
    assign lru_ptr_d = (int'(grant) == THREADS - 1) ? '0 : grant + IDX_W'(1);

    assign l2r_request_valid = req_valid;
    assign l2r_request_addr  = req_valid ? addr_q[grant] : '0;
    assign l2r_request_idx   = req_valid ? grant : '0;
    assign dmt_wake_bitmap   = wake_q;
    assign dmt_pending_count = pending_q;

    // Entry next-state. Response has the final word: the entry empties even
    // when a merge lands on it in the same cycle; that merging thread is
    // folded into the wake bitmap instead.
    always_comb begin
        for (int i = 0; i < THREADS; i++) begin
            state_d[i]   = state_q[i];
            addr_d[i]    = addr_q[i];
            waiters_d[i] = waiters_q[i];
            if (ack_fire && (grant == IDX_W'(i))) begin
                state_d[i] = ST_WAIT_RESPONSE;
            end
            if (merge_hit && (merge_idx == IDX_W'(i))) begin
                waiters_d[i] = waiters_q[i] | miss_onehot;
            end
            if (alloc && (dd_miss_thread_idx == IDX_W'(i))) begin
                state_d[i]   = ST_WAIT_ISSUE;
                addr_d[i]    = dd_miss_addr;
                waiters_d[i] = miss_onehot;
            end
            if (resp_fire && (l2_response_idx == IDX_W'(i))) begin
                state_d[i]   = ST_IDLE;
                waiters_d[i] = '0;
            end
        end

        wake_d = '0;
        if (resp_fire) begin
            wake_d = waiters_q[l2_response_idx];
            if (merge_hit && (merge_idx == l2_response_idx)) begin
                wake_d = wake_d | miss_onehot;
            end
        end

        pending_d = '0;
        for (int i = 0; i < THREADS; i++) begin
            if (state_d[i] != ST_IDLE) pending_d = pending_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < THREADS; i++) begin
                state_q[i]   <= ST_IDLE;
                addr_q[i]    <= '0;
                waiters_q[i] <= '0;
            end
            lru_ptr_q  <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            wake_q     <= '0;
            pending_q  <= '0;
        end else begin
            for (int i = 0; i < THREADS; i++) begin
                state_q[i]   <= state_d[i];
                addr_q[i]    <= addr_d[i];
                waiters_q[i] <= waiters_d[i];
            end
            if (ack_fire) lru_ptr_q <= lru_ptr_d;
            hold_q     <= req_valid && !l2r_request_ack;
            hold_idx_q <= grant;
            wake_q     <= wake_d;
            pending_q  <= pending_d;
        end
    end

    // Protocol checks on the suspend/wake contract
    a_miss_while_waiting : assert property (@(posedge clk) disable iff (reset)
        dd_miss_en |-> ((all_waiters & miss_onehot) == '0));
    a_alloc_not_idle : assert property (@(posedge clk) disable iff (reset)
        alloc |-> (state_q[dd_miss_thread_idx] == ST_IDLE));
    a_resp_not_waiting : assert property (@(posedge clk) disable iff (reset)
        l2_response_valid |-> (state_q[l2_response_idx] == ST_WAIT_RESPONSE));

endmodule

// File: tb/tb_dcache_miss_tracker.sv
// Testbench for dcache_miss_tracker: directed scenarios, expected requests and
// wake bitmaps queued by the driver and popped by a negedge monitor.

module tb_dcache_miss_tracker;

    localparam int THREADS = 4;
    localparam int LAW     = 26;
    localparam int IDX_W   = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             dd_miss_en;
    logic [LAW-1:0]   dd_miss_addr;
    logic [IDX_W-1:0] dd_miss_thread_idx;
    logic             l2r_request_valid;
    logic [LAW-1:0]   l2r_request_addr;
    logic [IDX_W-1:0] l2r_request_idx;
    logic             l2r_request_ack;
    logic             l2_response_valid;
    logic [IDX_W-1:0] l2_response_idx;
    logic [THREADS-1:0] dmt_wake_bitmap;
    logic [IDX_W:0]   dmt_pending_count;

    dcache_miss_tracker #(.THREADS(THREADS), .LINE_ADDR_WIDTH(LAW)) dut (
        .clk                (clk),
        .reset              (reset),
        .dd_miss_en         (dd_miss_en),
        .dd_miss_addr       (dd_miss_addr),
        .dd_miss_thread_idx (dd_miss_thread_idx),
        .l2r_request_valid  (l2r_request_valid),
        .l2r_request_addr   (l2r_request_addr),
        .l2r_request_idx    (l2r_request_idx),
        .l2r_request_ack    (l2r_request_ack),
        .l2_response_valid  (l2_response_valid),
        .l2_response_idx    (l2_response_idx),
        .dmt_wake_bitmap    (dmt_wake_bitmap),
        .dmt_pending_count  (dmt_pending_count)
    );

    // Scoreboard
    logic [LAW+IDX_W-1:0] req_exp_q[$];
    logic [THREADS-1:0]   wake_exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: a request transfer or a non-zero wake pops the matching queue
    always @(negedge clk) begin
        if (!reset && l2r_request_valid && l2r_request_ack) begin
            if (req_exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_request: got addr 0x%0h idx %0d expected none",
                         l2r_request_addr, l2r_request_idx);
            end else begin
                check("request", {l2r_request_addr, l2r_request_idx}, 32'(req_exp_q.pop_front()));
            end
        end
        if (!reset && dmt_wake_bitmap != '0) begin
            if (wake_exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_wake: got 0x%0h expected none", dmt_wake_bitmap);
            end else begin
                check("wake", 32'(dmt_wake_bitmap), 32'(wake_exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic miss(input int t, input logic [LAW-1:0] a);
        dd_miss_en         = 1'b1;
        dd_miss_thread_idx = IDX_W'(t);
        dd_miss_addr       = a;
        tick();
        dd_miss_en = 1'b0;
    endtask

    task automatic ack_one();
        l2r_request_ack = 1'b1;
        tick();
        l2r_request_ack = 1'b0;
    endtask

    task automatic respond(input int idx, input logic [THREADS-1:0] exp_wake);
        wake_exp_q.push_back(exp_wake);
        l2_response_valid = 1'b1;
        l2_response_idx   = IDX_W'(idx);
        tick();
        l2_response_valid = 1'b0;
    endtask

    task automatic exp_req(input logic [LAW-1:0] a, input int idx);
        req_exp_q.push_back({a, IDX_W'(idx)});
    endtask

    initial begin
        reset              = 1'b1;
        dd_miss_en         = 1'b0;
        dd_miss_addr       = '0;
        dd_miss_thread_idx = '0;
        l2r_request_ack    = 1'b0;
        l2_response_valid  = 1'b0;
        l2_response_idx    = '0;
        tick();
        tick();
        check("rst_valid", 32'(l2r_request_valid), 0);
        check("rst_addr", 32'(l2r_request_addr), 0);
        check("rst_idx", 32'(l2r_request_idx), 0);
        check("rst_wake", 32'(dmt_wake_bitmap), 0);
        check("rst_pending", 32'(dmt_pending_count), 0);
        reset = 1'b0;
        tick();

        // Single miss, thread 2
        exp_req(26'h0001234, 2);
        dd_miss_en = 1'b1; dd_miss_thread_idx = 2'd2; dd_miss_addr = 26'h0001234;
        #1;
        check("t1_no_early_valid", 32'(l2r_request_valid), 0);
        tick();
        dd_miss_en = 1'b0;
        check("t1_valid", 32'(l2r_request_valid), 1);
        check("t1_idx", 32'(l2r_request_idx), 2);
        check("t1_addr", 32'(l2r_request_addr), 32'h0001234);
        check("t1_pending1", 32'(dmt_pending_count), 1);
        ack_one();
        check("t1_valid_after_ack", 32'(l2r_request_valid), 0);
        respond(2, 4'b0100);
        check("t1_pending0", 32'(dmt_pending_count), 0);
        tick();

        // Merge: thread 0 then thread 3 on line 0x55
        exp_req(26'h55, 0);
        miss(0, 26'h55);
        tick();
        miss(3, 26'h55);
        check("t2_pending", 32'(dmt_pending_count), 1);
        check("t2_idx", 32'(l2r_request_idx), 0);
        ack_one();
        check("t2_single_request", 32'(l2r_request_valid), 0);
        respond(0, 4'b1001);
        check("t2_pending0", 32'(dmt_pending_count), 0);
        tick();

        // Merge colliding with the response
        exp_req(26'hAA, 1);
        miss(1, 26'hAA);
        ack_one();
        wake_exp_q.push_back(4'b0110);
        l2_response_valid = 1'b1; l2_response_idx = 2'd1;
        dd_miss_en = 1'b1; dd_miss_thread_idx = 2'd2; dd_miss_addr = 26'hAA;
        tick();
        l2_response_valid = 1'b0;
        dd_miss_en = 1'b0;
        check("t3_pending0", 32'(dmt_pending_count), 0);
        check("t3_no_request", 32'(l2r_request_valid), 0);
        tick();

        // Arbitration: grant held on entry 0, then round-robin 0..3
        for (int t = 0; t < 4; t++) begin
            miss(t, 26'h1000 + 26'(t));
            check("t4_valid_held", 32'(l2r_request_valid), 1);
            check("t4_idx_held", 32'(l2r_request_idx), 0);
        end
        tick();
        check("t4_idx_held_last", 32'(l2r_request_idx), 0);
        check("t4_pending4", 32'(dmt_pending_count), 4);
        for (int t = 0; t < 4; t++) exp_req(26'h1000 + 26'(t), t);
        l2r_request_ack = 1'b1;
        for (int t = 0; t < 4; t++) tick();
        l2r_request_ack = 1'b0;
        check("t4_drained", 32'(l2r_request_valid), 0);
        respond(0, 4'b0001);
        respond(1, 4'b0010);
        respond(2, 4'b0100);
        respond(3, 4'b1000);
        check("t4_pending0", 32'(dmt_pending_count), 0);
        tick();

        // Out-of-order responses
        exp_req(26'h100, 1);
        exp_req(26'h200, 2);
        miss(1, 26'h100);
        miss(2, 26'h200);
        ack_one();
        ack_one();
        check("t5_pending2", 32'(dmt_pending_count), 2);
        respond(2, 4'b0100);
        check("t5_pending1", 32'(dmt_pending_count), 1);
        respond(1, 4'b0010);
        check("t5_pending0", 32'(dmt_pending_count), 0);
        tick();

        // Reset with entries in WAIT_RESPONSE and WAIT_ISSUE
        exp_req(26'h300, 0);
        miss(0, 26'h300);
        miss(1, 26'h301);
        ack_one();
        check("t6_pending2", 32'(dmt_pending_count), 2);
        check("t6_idx1", 32'(l2r_request_idx), 1);
        check("t6_addr1", 32'(l2r_request_addr), 32'h301);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(l2r_request_valid), 0);
        check("t6_rst_addr", 32'(l2r_request_addr), 0);
        check("t6_rst_idx", 32'(l2r_request_idx), 0);
        check("t6_rst_wake", 32'(dmt_wake_bitmap), 0);
        check("t6_rst_pending", 32'(dmt_pending_count), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        exp_req(26'h400, 0);
        miss(0, 26'h400);
        check("t6_post_valid", 32'(l2r_request_valid), 1);
        check("t6_post_idx", 32'(l2r_request_idx), 0);
        check("t6_post_addr", 32'(l2r_request_addr), 32'h400);
        check("t6_post_pending", 32'(dmt_pending_count), 1);
        ack_one();
        respond(0, 4'b0001);
        check("t6_post_pending0", 32'(dmt_pending_count), 0);

        // Drain and report
        tick();
        tick();
        tick();
        check("req_queue_empty", 32'(req_exp_q.size()), 0);
        check("wake_queue_empty", 32'(wake_exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
